// File: rtl/dma_mst_pkg.sv
// Shared definitions for the dma_mst copy engine: register map, CTRL bit
// positions and the FSM state encoding.
package dma_mst_pkg;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_IE    = 1;
    localparam int CTRL_CLR   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RD,
        ST_WR,
        ST_FIN
    } state_t;

endpackage

// File: rtl/dma_mst.sv
// Single-channel memory-to-memory copy engine: CPU-side register slave plus a
// bus initiator that copies LEN words from SRC to DST, two cycles per word.
module dma_mst
    import dma_mst_pkg::*;
#(
    parameter int DW  = 16,
    parameter int AW  = 16,
    parameter int SAW = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DW-1:0]  din,
    input  logic [SAW-1:0] addr,
    input  logic           we,
    output logic [DW-1:0]  dout,
    output logic           m_req,
    input  logic           m_gnt,
    output logic [AW-1:0]  m_addr,
    output logic [DW-1:0]  m_din,
    output logic           m_we,
    input  logic [DW-1:0]  m_dout,
    output logic           done_int
);

    state_t        state;
    logic [AW-1:0] src_reg, dst_reg, cur_src, cur_dst;
    logic [DW-1:0] len_reg, remain;
    logic          ie, busy, done;

    logic wr_ctrl, start, clr;
    logic unused_addr_hi;

    // Only the low two address bits select a register; the rest is block-local.
    assign unused_addr_hi = ^addr[SAW-1:2];

    assign wr_ctrl = we && (addr[1:0] == REG_CTRL);
    assign start   = wr_ctrl && din[CTRL_START];
    assign clr     = wr_ctrl && din[CTRL_CLR];

    // Read data arrives one cycle after the address, so the write data must
    // pass straight through during WR rather than be registered.
    assign m_din = m_we ? m_dout : '0;

    // Slave register file and registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_reg <= '0;
            dst_reg <= '0;
            len_reg <= '0;
            ie      <= 1'b0;
            dout    <= '0;
        end else begin
            if (we && !busy && addr[1:0] == REG_SRC) src_reg <= AW'(din);
            if (we && !busy && addr[1:0] == REG_DST) dst_reg <= AW'(din);
            if (we && !busy && addr[1:0] == REG_LEN) len_reg <= din;
            if (wr_ctrl) ie <= din[CTRL_IE];

            case (addr[1:0])
                REG_SRC:  dout <= DW'(src_reg);
                REG_DST:  dout <= DW'(dst_reg);
                REG_LEN:  dout <= len_reg;
                REG_CTRL: dout <= DW'({done, ie, busy});
            endcase
        end
    end

    // Copy FSM; bus outputs are set on the transition into the state that
    // owns them, so every bus signal comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cur_src  <= '0;
            cur_dst  <= '0;
            remain   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            done_int <= 1'b0;
            m_req    <= 1'b0;
            m_addr   <= '0;
            m_we     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees the
            // pre-edge value of cur_src/remain regardless of statement order.
            done_int <= 1'b0;
            if (clr) done <= 1'b0;   // FIN below overrides a coincident clear

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (len_reg != '0) begin
                            cur_src <= src_reg;
                            cur_dst <= dst_reg;
                            remain  <= len_reg;
                            busy    <= 1'b1;
                            m_req   <= 1'b1;
                            state   <= ST_REQ;
                        end else begin
                            state   <= ST_FIN;
                        end
                    end
                end
                ST_REQ: begin
                    if (m_gnt) begin
                        m_addr <= cur_src;
                        state  <= ST_RD;
                    end
                end
                ST_RD: begin
                    m_addr <= cur_dst;
                    m_we   <= 1'b1;
                    state  <= ST_WR;
                end
                ST_WR: begin
                    cur_src <= cur_src + AW'(1);
                    cur_dst <= cur_dst + AW'(1);
                    remain  <= remain - DW'(1);
                    m_we    <= 1'b0;
                    if (remain == DW'(1)) begin
                        m_addr <= '0;
                        m_req  <= 1'b0;
                        state  <= ST_FIN;
                    end else if (m_gnt) begin
                        m_addr <= cur_src + AW'(1);
                        state  <= ST_RD;
                    end else begin
                        m_addr <= '0;
                        state  <= ST_REQ;
                    end
                end
                ST_FIN: begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    done_int <= ie;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_mst.sv
// Directed bench for dma_mst: bus RAM, a copy model producing the expected
// write stream, and a per-cycle compare process on the bus outputs.
module tb_dma_mst;
    import dma_mst_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = '0;
    logic [11:0] addr = '0;
    logic        we = 1'b0;
    logic [15:0] dout;
    logic        m_req;
    logic        m_gnt = 1'b0;
    logic [15:0] m_addr;
    logic [15:0] m_din;
    logic        m_we;
    logic [15:0] m_dout;
    logic        done_int;

    dma_mst #(.DW(16), .AW(16), .SAW(12)) dut (
        .clk(clk), .rst(rst), .din(din), .addr(addr), .we(we), .dout(dout),
        .m_req(m_req), .m_gnt(m_gnt), .m_addr(m_addr), .m_din(m_din),
        .m_we(m_we), .m_dout(m_dout), .done_int(done_int)
    );

    always #5 clk = ~clk;

    // Bus RAM: read data one cycle after the address; bench preloads via poke.
    logic [15:0] mem [0:65535];
    logic        poke_en = 1'b0;
    logic [15:0] poke_a = '0, poke_d = '0;

    always @(posedge clk) begin
        m_dout <= mem[m_addr];
        if (m_we) mem[m_addr] <= m_din;
        else if (poke_en) mem[poke_a] <= poke_d;
    end

    // Model: a copy is the ordered list of (source, destination, value) words.
    typedef struct packed {
        logic [15:0] s;
        logic [15:0] d;
        logic [15:0] v;
    } xfer_t;

    xfer_t       wq[$];
    xfer_t       cur_e;
    logic [15:0] ref_mem [0:65535];

    int total = 0, bad = 0;
    int cyc = 0;
    int done_cnt = 0, last_done_cyc = -1, req_cnt = 0;
    logic [15:0] prev_addr = '0;
    logic        prev_we = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_we   = 1'b0;
            prev_addr = '0;
        end else begin
            if (m_req) req_cnt++;
            if (done_int) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (m_we) begin
                check("write_under_req", m_req, 1);
                check("write_expected", wq.size() != 0, 1);
                if (wq.size() != 0) begin
                    cur_e = wq.pop_front();
                    check("rd_before_wr", prev_we, 0);
                    check("rd_addr", prev_addr, cur_e.s);
                    check("wr_addr", m_addr, cur_e.d);
                    check("wr_data", m_din, cur_e.v);
                end
            end else begin
                check("din_idle", m_din, 0);
                if (!m_req) check("addr_idle", m_addr, 0);
            end
            prev_we   = m_we;
            prev_addr = m_addr;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
        addr = {10'b0, a};
        din  = d;
        we   = 1'b1;
        tick(1);
        we   = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [15:0] d);
        addr = {10'b0, a};
        we   = 1'b0;
        tick(1);
        d = dout;
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        poke_a     = a;
        poke_d     = d;
        poke_en    = 1'b1;
        ref_mem[a] = d;
        tick(1);
        poke_en    = 1'b0;
    endtask

    task automatic expect_copy(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
        for (int i = 0; i < int'(len); i++) begin
            xfer_t e;
            e.s = src + 16'(i);
            e.d = dst + 16'(i);
            e.v = ref_mem[e.s];
            ref_mem[e.d] = e.v;
            wq.push_back(e);
        end
    endtask

    // Program SRC/DST/LEN, then write CTRL in cycle k0 (the START cycle).
    task automatic launch(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                          input logic [15:0] ctrl, output int k0);
        wr_reg(REG_SRC, src);
        wr_reg(REG_DST, dst);
        wr_reg(REG_LEN, len);
        expect_copy(src, dst, len);
        k0 = cyc;
        wr_reg(REG_CTRL, ctrl);
    endtask

    task automatic wait_done(input string name, input int budget);
        int start_cnt;
        start_cnt = done_cnt;
        for (int i = 0; i < budget && done_cnt == start_cnt; i++) tick(1);
        tick(3);
        check(name, done_cnt - start_cnt, 1);
        check({name, "_drained"}, wq.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k0;
        int          r0, d0;
        logic [15:0] v;

        // Reset state
        tick(3);
        check("rst_dout", dout, 0);
        check("rst_m_req", m_req, 0);
        check("rst_m_we", m_we, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_done_int", done_int, 0);
        rst = 1'b0;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            rd_reg(2'(i), v);
            check("rst_reg", v, 0);
        end

        // Basic copy of four words with continuous grant
        poke(16'h0010, 16'hA1A1);
        poke(16'h0011, 16'hB2B2);
        poke(16'h0012, 16'hC3C3);
        poke(16'h0013, 16'hD4D4);
        m_gnt = 1'b1;
        launch(16'h0010, 16'h0040, 16'd4, 16'h0003, k0);
        rd_reg(REG_CTRL, v);
        check("t1_stat_busy", v, 16'h0003);
        wait_done("t1_done", 40);
        check("t1_done_cycle", last_done_cyc - k0, 11);
        check("t1_mem40", mem[16'h0040], 16'hA1A1);
        check("t1_mem41", mem[16'h0041], 16'hB2B2);
        check("t1_mem42", mem[16'h0042], 16'hC3C3);
        check("t1_mem43", mem[16'h0043], 16'hD4D4);
        rd_reg(REG_CTRL, v);
        check("t1_stat_done", v, 16'h0006);

        // Zero-length start: no bus activity, DONE after FIN, no interrupt
        wr_reg(REG_CTRL, 16'h0004);
        rd_reg(REG_CTRL, v);
        check("t2_stat_clr", v, 16'h0000);
        wr_reg(REG_LEN, 16'h0000);
        r0 = req_cnt;
        d0 = done_cnt;
        wr_reg(REG_CTRL, 16'h0001);
        rd_reg(REG_CTRL, v);
        check("t2_stat_c1", v, 16'h0000);
        rd_reg(REG_CTRL, v);
        check("t2_stat_c2", v, 16'h0004);
        tick(3);
        check("t2_no_req", req_cnt - r0, 0);
        check("t2_no_int", done_cnt - d0, 0);

        // Grant withheld for five cycles after START
        m_gnt = 1'b0;
        poke(16'h0100, 16'h1234);
        poke(16'h0101, 16'h5678);
        poke(16'h0102, 16'h9ABC);
        poke(16'h0103, 16'hDEF0);
        launch(16'h0100, 16'h0180, 16'd4, 16'h0003, k0);
        for (int i = 0; i < 5; i++) begin
            check("t3_req_held", m_req, 1);
            check("t3_no_we", m_we, 0);
            tick(1);
        end
        m_gnt = 1'b1;
        wait_done("t3_done", 40);
        check("t3_done_cycle", last_done_cyc - k0, 16);
        check("t3_mem183", mem[16'h0183], 16'hDEF0);

        // Grant dropped after the second WR for three cycles
        poke(16'h0700, 16'h0707);
        poke(16'h0701, 16'h1717);
        poke(16'h0702, 16'h2727);
        poke(16'h0703, 16'h3737);
        launch(16'h0700, 16'h0780, 16'd4, 16'h0003, k0);
        tick(4);
        m_gnt = 1'b0;
        tick(1);
        check("t4_req_wait1", m_req, 1);
        check("t4_we_wait1", m_we, 0);
        tick(1);
        check("t4_req_wait2", m_req, 1);
        check("t4_we_wait2", m_we, 0);
        tick(1);
        m_gnt = 1'b1;
        wait_done("t4_done", 40);
        check("t4_done_cycle", last_done_cyc - k0, 14);
        check("t4_mem782", mem[16'h0782], 16'h2727);

        // Source address wraps through 0xFFFF
        poke(16'hFFFE, 16'h1111);
        poke(16'hFFFF, 16'h2222);
        poke(16'h0000, 16'h3333);
        launch(16'hFFFE, 16'h0200, 16'd3, 16'h0003, k0);
        wait_done("t5_done", 40);
        check("t5_done_cycle", last_done_cyc - k0, 9);
        check("t5_mem200", mem[16'h0200], 16'h1111);
        check("t5_mem201", mem[16'h0201], 16'h2222);
        check("t5_mem202", mem[16'h0202], 16'h3333);

        // LEN write and START while BUSY are ignored
        poke(16'h0300, 16'h4444);
        poke(16'h0301, 16'h5555);
        poke(16'h0302, 16'h6666);
        poke(16'h0303, 16'h7777);
        launch(16'h0300, 16'h0400, 16'd4, 16'h0003, k0);
        wr_reg(REG_LEN, 16'd9);
        wr_reg(REG_CTRL, 16'h0003);
        rd_reg(REG_LEN, v);
        check("t6_len_kept", v, 16'd4);
        wait_done("t6_done", 40);
        check("t6_done_cycle", last_done_cyc - k0, 11);
        r0 = req_cnt;
        tick(5);
        check("t6_no_restart", req_cnt - r0, 0);

        // Reset in the middle of a transfer
        poke(16'h0500, 16'h0A0A);
        poke(16'h0501, 16'h0B0B);
        poke(16'h0502, 16'h0C0C);
        poke(16'h0503, 16'h0D0D);
        launch(16'h0500, 16'h0600, 16'd4, 16'h0003, k0);
        for (int i = 0; i < 40 && !m_we; i++) tick(1);
        check("t7_in_write", m_we, 1);
        rst = 1'b1;
        #1;
        check("t7_we_drop", m_we, 0);
        check("t7_req_drop", m_req, 0);
        check("t7_addr_drop", m_addr, 0);
        check("t7_din_drop", m_din, 0);
        wq.delete();
        tick(2);
        rst = 1'b0;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            rd_reg(2'(i), v);
            check("t7_reg_zero", v, 0);
        end
        r0 = req_cnt;
        tick(3);
        check("t7_idle", req_cnt - r0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
